// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the execute stage and the data memory.
// The master issues one request per cycle (no backpressure) and receives one
// response per accepted request, READ_LATENCY cycles later.
interface data_memory_ctrl_if;
    logic        req_valid;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] memory_address;
    logic [31:0] WD2;
    logic        resp_valid;
    logic [31:0] Data;
    logic        err_misaligned;
    logic        err_range;
    logic        err_illegal;

    modport master (
        output req_valid, MemWrite, funct3, memory_address, WD2,
        input  resp_valid, Data, err_misaligned, err_range, err_illegal
    );

    modport slave (
        input  req_valid, MemWrite, funct3, memory_address, WD2,
        output resp_valid, Data, err_misaligned, err_range, err_illegal
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// RV32I data memory with byte-lane stores, sign/zero-extended sub-word loads,
// a configurable read pipeline and per-request error flags.
// Storage is four byte-wide RAM lanes so each lane infers a plain block RAM
// with a registered read; lane extraction happens at the end of the pipeline.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LAST  = READ_LATENCY - 1;

    // Request decode (combinational, feeds the write port and stage 0 only)
    logic [1:0]       req_off;
    logic [IDX_W-1:0] req_idx;
    logic             req_accept;
    logic             req_illegal;
    logic             req_misaligned;
    logic             req_range;
    logic             wr_en;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    // Classify the request; lower-priority flags are masked by higher ones
    always_comb begin
        req_off    = bus.memory_address[1:0];
        req_idx    = bus.memory_address[IDX_W+1:2];
        req_accept = bus.req_valid && !rst;

        // Stores only know B/H/W; loads additionally accept BU/HU
        if (bus.MemWrite) begin
            req_illegal = (bus.funct3 > 3'b010);
        end else begin
            req_illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
        end

        req_misaligned = 1'b0;
        if (!req_illegal) begin
            case (bus.funct3[1:0])
                2'b01:   req_misaligned = req_off[0];
                2'b10:   req_misaligned = (req_off != 2'b00);
                default: req_misaligned = 1'b0;
            endcase
        end

        // Any upper address bit set means the word index is past the array
        req_range = !req_illegal && !req_misaligned &&
                    (|bus.memory_address[31:IDX_W+2]);

        wr_en = req_accept && bus.MemWrite &&
                !(req_illegal || req_misaligned || req_range);

        // Replicate narrow data across lanes so the enable alone picks the lane
        case (bus.funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << req_off;
                wr_data = {4{bus.WD2[7:0]}};
            end
            2'b01: begin
                wr_be   = 4'b0011 << req_off;
                wr_data = {2{bus.WD2[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = bus.WD2;
            end
        endcase
    end

    // Byte-lane storage; contents survive reset
    logic [31:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_reg;

            // Lane write at the store edge, registered read at the load edge
            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    mem[req_idx] <= wr_data[gi*8 +: 8];
                end
                if (req_accept) begin
                    rd_reg <= mem[req_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_reg;
        end
    endgenerate

    // Control pipeline: stage 0 is captured alongside the RAM read
    logic       st_valid_reg  [READ_LATENCY];
    logic       st_store_reg  [READ_LATENCY];
    logic [2:0] st_funct3_reg [READ_LATENCY];
    logic [1:0] st_off_reg    [READ_LATENCY];
    logic [2:0] st_err_reg    [READ_LATENCY]; // {illegal, misaligned, range}

    // Advance the control stages; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                st_valid_reg[k]  <= 1'b0;
                st_store_reg[k]  <= 1'b0;
                st_funct3_reg[k] <= 3'b000;
                st_off_reg[k]    <= 2'b00;
                st_err_reg[k]    <= 3'b000;
            end
        end else begin
            st_valid_reg[0]  <= bus.req_valid;
            st_store_reg[0]  <= bus.MemWrite;
            st_funct3_reg[0] <= bus.funct3;
            st_off_reg[0]    <= req_off;
            st_err_reg[0]    <= bus.req_valid ?
                                {req_illegal, req_misaligned, req_range} : 3'b000;
            for (int k = 1; k < READ_LATENCY; k++) begin
                st_valid_reg[k]  <= st_valid_reg[k-1];
                st_store_reg[k]  <= st_store_reg[k-1];
                st_funct3_reg[k] <= st_funct3_reg[k-1];
                st_off_reg[k]    <= st_off_reg[k-1];
                st_err_reg[k]    <= st_err_reg[k-1];
            end
        end
    end

    // Raw word pipeline; the RAM read register already counts as stage 0
    logic [31:0] last_word;

    generate
        if (READ_LATENCY == 1) begin : g_word_direct
            assign last_word = rd_word;
        end else begin : g_word_pipe
            logic [31:0] word_reg [1:READ_LATENCY-1];

            // Carry the raw word alongside its control stage
            always_ff @(posedge clk) begin
                word_reg[1] <= rd_word;
                for (int k = 2; k < READ_LATENCY; k++) begin
                    word_reg[k] <= word_reg[k-1];
                end
            end

            assign last_word = word_reg[READ_LATENCY-1];
        end
    endgenerate

    // Final stage: pick the lane(s) and extend, all from registered state
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] ext_word;
    logic        resp_ok;

    // Lane select and sign/zero extension for the oldest response
    always_comb begin
        case (st_off_reg[LAST])
            2'd0:    lane_byte = last_word[7:0];
            2'd1:    lane_byte = last_word[15:8];
            2'd2:    lane_byte = last_word[23:16];
            default: lane_byte = last_word[31:24];
        endcase
        lane_half = st_off_reg[LAST][1] ? last_word[31:16] : last_word[15:0];

        case (st_funct3_reg[LAST])
            3'b000:  ext_word = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  ext_word = {{16{lane_half[15]}}, lane_half};
            3'b010:  ext_word = last_word;
            3'b100:  ext_word = {24'h000000, lane_byte};
            3'b101:  ext_word = {16'h0000, lane_half};
            default: ext_word = 32'h0000_0000;
        endcase

        resp_ok = st_valid_reg[LAST] && !st_store_reg[LAST] &&
                  (st_err_reg[LAST] == 3'b000);
    end

    assign bus.Data           = resp_ok ? ext_word : 32'h0000_0000;
    assign bus.resp_valid     = st_valid_reg[LAST];
    assign bus.err_illegal    = st_valid_reg[LAST] & st_err_reg[LAST][2];
    assign bus.err_misaligned = st_valid_reg[LAST] & st_err_reg[LAST][1];
    assign bus.err_range      = st_valid_reg[LAST] & st_err_reg[LAST][0];
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one instance at READ_LATENCY=1 and one at
// READ_LATENCY=3, both DEPTH_WORDS=1024. Expected responses come from a
// byte-addressed memory model that applies the RV32I load/store rules directly.
module tb_data_memory_ctrl;
    localparam int DEPTH = 1024;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    data_memory_ctrl_if bus_a ();
    data_memory_ctrl_if bus_b ();

    data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT_A)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT_B)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [2:0]  err;  // {illegal, misaligned, range}
    } resp_t;

    resp_t       q_a[$];
    resp_t       q_b[$];
    logic [7:0]  model_mem [2][4096];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    // Request currently presented to each DUT, as the bench knows it
    logic        r_v  [2];
    logic        r_w  [2];
    logic [2:0]  r_f3 [2];
    logic [31:0] r_ad [2];
    logic [31:0] r_wd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic req(input int w, input logic mw, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] wd);
        r_v[w] = 1'b1; r_w[w] = mw; r_f3[w] = f3; r_ad[w] = ad; r_wd[w] = wd;
        if (w == 0) begin
            bus_a.req_valid = 1'b1; bus_a.MemWrite = mw; bus_a.funct3 = f3;
            bus_a.memory_address = ad; bus_a.WD2 = wd;
        end else begin
            bus_b.req_valid = 1'b1; bus_b.MemWrite = mw; bus_b.funct3 = f3;
            bus_b.memory_address = ad; bus_b.WD2 = wd;
        end
    endtask

    task automatic idle_all();
        r_v[0] = 1'b0; r_v[1] = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.MemWrite = 1'b0; bus_a.funct3 = 3'b000;
        bus_a.memory_address = 32'h0; bus_a.WD2 = 32'h0;
        bus_b.req_valid = 1'b0; bus_b.MemWrite = 1'b0; bus_b.funct3 = 3'b000;
        bus_b.memory_address = 32'h0; bus_b.WD2 = 32'h0;
    endtask

    // Reference: apply one accepted request to the byte memory, return its response
    task automatic model_req(input int w, output resp_t r);
        int          size;
        logic        ill, mis, rng;
        logic [31:0] v;
        ill  = r_w[w] ? (r_f3[w] > 3'd2) : (r_f3[w] == 3'd3 || r_f3[w] >= 3'd6);
        size = 1 << r_f3[w][1:0];
        mis  = !ill && ((r_ad[w] % size) != 0);
        rng  = !ill && !mis && ((r_ad[w] >> 2) >= DEPTH);
        r.due  = 0;
        r.err  = {ill, mis, rng};
        r.data = 32'h0;
        if (!(ill || mis || rng)) begin
            if (r_w[w]) begin
                for (int i = 0; i < size; i++)
                    model_mem[w][r_ad[w] + i] = r_wd[w][8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++)
                    v = v | (32'(model_mem[w][r_ad[w] + i]) << (8*i));
                if (!r_f3[w][2] && size < 4 && v[8*size-1])
                    v = v | (32'hFFFF_FFFF << (8*size));
                r.data = v;
            end
        end
    endtask

    task automatic check_out(input int w);
        logic        rv;
        logic [31:0] d;
        logic [2:0]  e;
        logic        exp_v;
        resp_t       ex;
        string       nm;
        ex.due = 0; ex.data = 32'h0; ex.err = 3'b000; exp_v = 1'b0;
        if (w == 0) begin
            nm = "a"; rv = bus_a.resp_valid; d = bus_a.Data;
            e = {bus_a.err_illegal, bus_a.err_misaligned, bus_a.err_range};
            if (q_a.size() > 0 && q_a[0].due == cyc) begin ex = q_a.pop_front(); exp_v = 1'b1; end
        end else begin
            nm = "b"; rv = bus_b.resp_valid; d = bus_b.Data;
            e = {bus_b.err_illegal, bus_b.err_misaligned, bus_b.err_range};
            if (q_b.size() > 0 && q_b[0].due == cyc) begin ex = q_b.pop_front(); exp_v = 1'b1; end
        end
        chk($sformatf("%s.resp_valid", nm), 32'(rv), 32'(exp_v));
        chk($sformatf("%s.Data", nm), d, ex.data);
        chk($sformatf("%s.err", nm), 32'(e), 32'(ex.err));
        if (exp_v)
            $display("[edge %0d] dut_%s resp data=%h err(ill,mis,rng)=%b", cyc, nm, d, e);
    endtask

    // One clock: model what the DUTs sampled, then check outputs 1 ns later
    task automatic tick();
        resp_t r;
        @(posedge clk);
        cyc++;
        if (rst_a) q_a.delete();
        else if (r_v[0]) begin model_req(0, r); r.due = cyc + LAT_A - 1; q_a.push_back(r); end
        if (rst_b) q_b.delete();
        else if (r_v[1]) begin model_req(1, r); r.due = cyc + LAT_B - 1; q_b.push_back(r); end
        #1;
        check_out(0);
        check_out(1);
        idle_all();
    endtask

    initial begin
        logic [31:0] ad;
        idle_all();
        rst_a = 1'b1; rst_b = 1'b1;
        // Reset state, with a request present that must be ignored
        req(0, 1'b1, F_W, 32'h0, 32'hFFFF_FFFF);
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0;

        // Give the low 128 words known contents in both instances
        for (int i = 0; i < 128; i++) begin
            req(0, 1'b1, F_W, 32'(i*4), $urandom);
            req(1, 1'b1, F_W, 32'(i*4), $urandom);
            tick();
        end

        // Word store/load, sub-word stores and extension
        req(0, 1'b1, F_W,  32'h100, 32'hDEAD_BEEF); tick();
        req(0, 1'b0, F_W,  32'h100, 32'h0);         tick();
        req(0, 1'b1, F_B,  32'h102, 32'h0000_007F); tick();
        req(0, 1'b0, F_B,  32'h102, 32'h0);         tick();
        req(0, 1'b0, F_B,  32'h103, 32'h0);         tick();
        req(0, 1'b0, F_BU, 32'h103, 32'h0);         tick();
        req(0, 1'b0, F_W,  32'h100, 32'h0);         tick();
        req(0, 1'b1, F_H,  32'h10A, 32'h1234_8086); tick();
        req(0, 1'b0, F_H,  32'h10A, 32'h0);         tick();
        req(0, 1'b0, F_HU, 32'h10A, 32'h0);         tick();
        req(0, 1'b0, F_W,  32'h108, 32'h0);         tick();
        // Error cases and their priority
        req(0, 1'b0, F_H,  32'h101, 32'h0);         tick();
        req(0, 1'b1, F_W,  32'h106, 32'h5555_5555); tick();
        req(0, 1'b0, F_W,  32'h104, 32'h0);         tick();
        req(0, 1'b0, 3'b011, 32'h100, 32'h0);       tick();
        req(0, 1'b1, F_BU, 32'h100, 32'hFFFF_FFFF); tick();
        req(0, 1'b1, 3'b111, 32'h1003, 32'h0);      tick();
        req(0, 1'b0, F_W,  32'h1002, 32'h0);        tick();
        req(0, 1'b0, F_W,  32'h1000, 32'h0);        tick();
        req(0, 1'b1, F_W,  32'h1000, 32'hCAFE_F00D); tick();
        req(0, 1'b0, F_W,  32'h0,   32'h0);         tick();
        // Load right after a store to the same word
        req(0, 1'b1, F_W,  32'h40,  32'h1234_5678); tick();
        req(0, 1'b0, F_W,  32'h40,  32'h0);         tick();
        req(0, 1'b0, F_W,  32'h100, 32'h0);         tick();

        // Latency 3: four back-to-back loads, then drain
        req(1, 1'b0, F_W,  32'h0,  32'h0); tick();
        req(1, 1'b0, F_B,  32'h5,  32'h0); tick();
        req(1, 1'b0, F_HU, 32'h2,  32'h0); tick();
        req(1, 1'b0, F_H,  32'hC,  32'h0); tick();
        for (int i = 0; i < 4; i++) tick();

        // Reset while loads are in flight drops all of them
        req(1, 1'b0, F_W, 32'h10, 32'h0); tick();
        req(1, 1'b0, F_W, 32'h14, 32'h0); tick();
        rst_b = 1'b1;
        req(1, 1'b0, F_W, 32'h18, 32'h0); tick();
        req(1, 1'b0, F_W, 32'h1C, 32'h0); tick();
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        // First request after reset is accepted
        req(1, 1'b0, F_W, 32'h20, 32'h0); tick();
        for (int i = 0; i < 3; i++) tick();

        // Random mix on both instances
        for (int n = 0; n < 400; n++) begin
            for (int w = 0; w < 2; w++) begin
                if ($urandom_range(3) != 0) begin
                    ad = ($urandom_range(7) == 0) ? ($urandom | 32'h0000_1000)
                                                  : 32'($urandom_range(511));
                    req(w, 1'($urandom_range(1)), 3'($urandom_range(7)), ad, $urandom);
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised RV32I data memory with sub-word access. It supports LB/LH/LW/LBU/LHU loads and SB/SH/SW stores with byte-lane write enables and sign/zero extension. It also has a configurable read pipeline latency, and every accepted request produces exactly one response with error flags. It sits between the execute stage and the write-back mux, replacing the fixed word-only data RAM.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- READ_LATENCY, 1: cycles from request to response; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present this cycle; always accepted (no backpressure).
- MemWrite  in  1  1 = store, 0 = load; sampled when req_valid=1.
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- memory_address  in  32  byte address.
- WD2  in  32  store data; byte/half taken from the low bits.
- resp_valid  out  1  response strobe, one per accepted request.
- Data  out  32  load result, extended; 0 for stores and errored requests.
- err_misaligned  out  1  the half access had addr[0]=1, or the word access had addr[1:0]≠0.
- err_range  out  1  word index addr[31:2] ≥ DEPTH_WORDS.
- err_illegal  out  1  funct3 is 011, 110 or 111 (for a store, any funct3 other than 000/001/010).

## Operation
- Storage: DEPTH_WORDS × 32 bits, byte-lane writable. Index = addr[log2(DEPTH_WORDS)+1:2]. Contents are not cleared by rst.
- Error priority for flag setting: illegal > misaligned > range. Only the highest-priority flag is set. Any error suppresses the write and forces Data=0.
- Store byte enables, with off=addr[1:0]:
  - SB: lane off, data WD2[7:0].
  - SH: lanes off and off+1, data WD2[15:0].
  - SW: all lanes.
  - Lanes that are not enabled retain their old contents.
  - The store commits at the clock edge where req_valid=1.
- Load: the word is read at the request edge. Lane selection and extension happen in the final pipeline stage, using the registered funct3 and off.
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- Pipeline: READ_LATENCY stages, each carrying valid, is_store, funct3, off, the three error flags and the raw word. The outputs come from the last stage.
- Hazard: a load issued the cycle after a store to the same word returns the post-store contents. There is no forwarding path; storage is updated at the store edge and read at the next edge.

## Timing
- Request at edge N gives resp_valid=1 during cycle N+READ_LATENCY, with Data and the error flags valid in that same cycle.
- Back-to-back requests give back-to-back responses, in order, with a throughput of 1 per cycle.
- resp_valid is a single-cycle pulse per request. resp_valid=0 implies Data=0 and all err_*=0.
- Reset, evaluated at an edge with rst=1:
  - All stage valids, Data and err_* are cleared to 0.
  - In-flight responses are dropped.
  - A request in the same cycle as rst=1 is ignored: no write, no response.
- After rst deasserts, the first request is accepted on the next edge.
- No combinational path from inputs to outputs.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100 → resp_valid 1 cycle after each request (READ_LATENCY=1); load Data=0xDEADBEEF; store response Data=0, flags 0.
- After that store, SB 0x7F to 0x102, then LB 0x102 → 0x0000007F, LB 0x103 → 0xFFFFFFDE, LBU 0x103 → 0x000000DE, LW 0x100 → 0xDE7FBEEF.
- LH 0x101 → err_misaligned=1, Data=0. SW 0x106 → err_misaligned=1 and the memory word at 0x104 is unchanged. funct3=011 → err_illegal=1.
- With DEPTH_WORDS=1024: LW 0x1000 → err_range=1, Data=0. SW 0x1000 does not alias onto word 0; a later LW 0x0 returns its prior value.
- With READ_LATENCY=3: four consecutive loads produce four consecutive resp_valid pulses in cycles N+3..N+6, in order. Asserting rst in cycle N+2 drops all of them (no resp_valid afterwards).
- SW 0x12345678 to 0x40 at edge N, then LW 0x40 at edge N+1 → returns 0x12345678.
